// File: rtl/id_ex_stage_if.sv
// Signal bundle between decode, the ID/EX stage and the forwarding producers.
// master: the surrounding pipeline; slave: the id_ex_stage register.
interface id_ex_stage_if #(parameter int CTRL_W = 8);
  logic              id_valid;
  logic [31:0]       id_pc;
  logic [4:0]        id_rs1;
  logic [4:0]        id_rs2;
  logic [4:0]        id_rd;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [31:0]       id_rd1;
  logic [31:0]       id_rd2;
  logic [31:0]       id_imm;
  logic [CTRL_W-1:0] id_ctrl;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              ex_flush;
  logic [4:0]        exm_rd;
  logic              exm_reg_write;
  logic [31:0]       exm_result;
  logic [4:0]        wb_rd;
  logic              wb_reg_write;
  logic [31:0]       wb_result;

  logic              stall_id;
  logic              ex_valid;
  logic [31:0]       ex_pc;
  logic [31:0]       ex_imm;
  logic [4:0]        ex_rs1;
  logic [4:0]        ex_rs2;
  logic [4:0]        ex_rd;
  logic [31:0]       ex_op_a;
  logic [31:0]       ex_op_b;
  logic [CTRL_W-1:0] ex_ctrl;
  logic              ex_reg_write;
  logic              ex_mem_read;

  modport master (
    output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
           id_rd1, id_rd2, id_imm, id_ctrl, id_reg_write, id_mem_read, ex_flush,
           exm_rd, exm_reg_write, exm_result, wb_rd, wb_reg_write, wb_result,
    input  stall_id, ex_valid, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_rd,
           ex_op_a, ex_op_b, ex_ctrl, ex_reg_write, ex_mem_read
  );

  modport slave (
    input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
           id_rd1, id_rd2, id_imm, id_ctrl, id_reg_write, id_mem_read, ex_flush,
           exm_rd, exm_reg_write, exm_result, wb_rd, wb_reg_write, wb_result,
    output stall_id, ex_valid, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_rd,
           ex_op_a, ex_op_b, ex_ctrl, ex_reg_write, ex_mem_read
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard stall, branch flush and operand forwarding.
// Define ID_EX_FWD_EN to enable EX/MEM and MEM/WB forwarding; otherwise any RAW stalls.
module id_ex_stage #(
  parameter int CTRL_W = 8
) (
  input logic   clk,
  input logic   reset,
  id_ex_stage_if.slave bus
);

  logic              ex_valid_q;
  logic              ex_reg_write_q;
  logic              ex_mem_read_q;
  logic [31:0]       ex_pc_q;
  logic [31:0]       ex_imm_q;
  logic [31:0]       rd1_q;
  logic [31:0]       rd2_q;
  logic [4:0]        ex_rs1_q;
  logic [4:0]        ex_rs2_q;
  logic [4:0]        ex_rd_q;
  logic [CTRL_W-1:0] ex_ctrl_q;

  logic        hz;
  logic        bubble;
  logic        id_reads_ex_rd;
  logic [31:0] op_a;
  logic [31:0] op_b;

  // x0 never matches, so a zero destination can never cause a stall
  function automatic logic raw(input logic [4:0] rs, input logic use_rs, input logic [4:0] rd);
    return use_rs && (rs != 5'd0) && (rs == rd);
  endfunction

  assign id_reads_ex_rd = raw(bus.id_rs1, bus.id_use_rs1, ex_rd_q) |
                          raw(bus.id_rs2, bus.id_use_rs2, ex_rd_q);

`ifdef ID_EX_FWD_EN
  assign hz = bus.id_valid & ex_valid_q & ex_mem_read_q & id_reads_ex_rd;

  // EX/MEM is the younger producer and wins over MEM/WB
  always_comb begin
    op_a = rd1_q;
    op_b = rd2_q;
    if (bus.exm_reg_write && (bus.exm_rd != 5'd0) && (bus.exm_rd == ex_rs1_q))
      op_a = bus.exm_result;
    else if (bus.wb_reg_write && (bus.wb_rd != 5'd0) && (bus.wb_rd == ex_rs1_q))
      op_a = bus.wb_result;
    if (bus.exm_reg_write && (bus.exm_rd != 5'd0) && (bus.exm_rd == ex_rs2_q))
      op_b = bus.exm_result;
    else if (bus.wb_reg_write && (bus.wb_rd != 5'd0) && (bus.wb_rd == ex_rs2_q))
      op_b = bus.wb_result;
  end
`else
  logic id_reads_exm_rd;
  logic unused_fwd;

  assign id_reads_exm_rd = raw(bus.id_rs1, bus.id_use_rs1, bus.exm_rd) |
                           raw(bus.id_rs2, bus.id_use_rs2, bus.exm_rd);

  // MEM/WB needs no check: the register file writes on negedge ahead of the read
  assign hz = bus.id_valid & ((ex_valid_q & ex_reg_write_q & id_reads_ex_rd) |
                              (bus.exm_reg_write & id_reads_exm_rd));

  assign op_a = rd1_q;
  assign op_b = rd2_q;
  assign unused_fwd = ^{bus.exm_result, bus.wb_rd, bus.wb_reg_write, bus.wb_result};
`endif

  assign bubble       = bus.ex_flush | hz;
  assign bus.stall_id = hz & ~bus.ex_flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q     <= 1'b0;
      ex_reg_write_q <= 1'b0;
      ex_mem_read_q  <= 1'b0;
      ex_ctrl_q      <= '0;
      ex_pc_q        <= '0;
      ex_imm_q       <= '0;
      ex_rs1_q       <= '0;
      ex_rs2_q       <= '0;
      ex_rd_q        <= '0;
      rd1_q          <= '0;
      rd2_q          <= '0;
    end else if (bubble) begin
      // data fields hold; only the qualifiers and control are cleared
      ex_valid_q     <= 1'b0;
      ex_reg_write_q <= 1'b0;
      ex_mem_read_q  <= 1'b0;
      ex_ctrl_q      <= '0;
    end else begin
      ex_valid_q     <= bus.id_valid;
      ex_reg_write_q <= bus.id_reg_write & bus.id_valid;
      ex_mem_read_q  <= bus.id_mem_read & bus.id_valid;
      ex_ctrl_q      <= bus.id_ctrl;
      ex_pc_q        <= bus.id_pc;
      ex_imm_q       <= bus.id_imm;
      ex_rs1_q       <= bus.id_rs1;
      ex_rs2_q       <= bus.id_rs2;
      ex_rd_q        <= bus.id_rd;
      rd1_q          <= bus.id_rd1;
      rd2_q          <= bus.id_rd2;
    end
  end

  assign bus.ex_valid     = ex_valid_q;
  assign bus.ex_pc        = ex_pc_q;
  assign bus.ex_imm       = ex_imm_q;
  assign bus.ex_rs1       = ex_rs1_q;
  assign bus.ex_rs2       = ex_rs2_q;
  assign bus.ex_rd        = ex_rd_q;
  assign bus.ex_op_a      = op_a;
  assign bus.ex_op_b      = op_b;
  assign bus.ex_ctrl      = ex_ctrl_q;
  assign bus.ex_reg_write = ex_reg_write_q;
  assign bus.ex_mem_read  = ex_mem_read_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: vector table per build (forwarding on/off) with a scoreboard
// of post-edge EX state, plus reset sequences.
module tb_id_ex_stage;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_ex_stage_if #(.CTRL_W(CW)) bus ();
  id_ex_stage #(.CTRL_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic valid; logic [31:0] pc; logic [4:0] rs1, rs2, rd; logic u1, u2;
    logic [31:0] rd1, rd2, imm; logic [7:0] ctrl; logic rw, mr, flush;
    logic [4:0] exm_rd; logic exm_rw; logic [31:0] exm_res;
    logic [4:0] wb_rd; logic wb_rw; logic [31:0] wb_res;
    logic e_stall, chk_op; logic [31:0] e_op_a, e_op_b;
    logic e_valid; logic [31:0] e_pc; logic [4:0] e_rd; logic e_rw, e_mr;
    logic [7:0] e_ctrl; logic chk_imm; logic [31:0] e_imm;
  } vec_t;

  typedef struct {
    int idx; logic valid; logic [31:0] pc; logic [4:0] rd; logic rw, mr;
    logic [7:0] ctrl; logic chk_imm; logic [31:0] imm;
  } post_t;

  vec_t  tbl[$];
  post_t sb[$];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t vid(input vec_t v0, input logic [31:0] valid, pc, rs1, rs2, u1, u2,
                               rd, rd1, rd2, imm, ctrl, rw, mr);
    vec_t v = v0;
    v.valid = valid[0]; v.pc = pc; v.rs1 = rs1[4:0]; v.rs2 = rs2[4:0];
    v.u1 = u1[0]; v.u2 = u2[0]; v.rd = rd[4:0]; v.rd1 = rd1; v.rd2 = rd2;
    v.imm = imm; v.ctrl = ctrl[7:0]; v.rw = rw[0]; v.mr = mr[0]; v.flush = 1'b0;
    return v;
  endfunction

  function automatic vec_t vpr(input vec_t v0, input logic [31:0] exm_rd, exm_rw, exm_res,
                               wb_rd, wb_rw, wb_res);
    vec_t v = v0;
    v.exm_rd = exm_rd[4:0]; v.exm_rw = exm_rw[0]; v.exm_res = exm_res;
    v.wb_rd = wb_rd[4:0]; v.wb_rw = wb_rw[0]; v.wb_res = wb_res;
    return v;
  endfunction

  function automatic vec_t vnow(input vec_t v0, input logic [31:0] stall, chk_op, a, b);
    vec_t v = v0;
    v.e_stall = stall[0]; v.chk_op = chk_op[0]; v.e_op_a = a; v.e_op_b = b;
    return v;
  endfunction

  function automatic vec_t vpost(input vec_t v0, input logic [31:0] valid, pc, rd, rw, mr, ctrl);
    vec_t v = v0;
    v.e_valid = valid[0]; v.e_pc = pc; v.e_rd = rd[4:0]; v.e_rw = rw[0]; v.e_mr = mr[0];
    v.e_ctrl = ctrl[7:0]; v.chk_imm = 1'b0;
    return v;
  endfunction

  function automatic vec_t vimm(input vec_t v0, input logic [31:0] imm);
    vec_t v = v0;
    v.chk_imm = 1'b1; v.e_imm = imm;
    return v;
  endfunction

`ifdef ID_EX_FWD_EN
  task automatic build_table();
    vec_t v = '{default: '0};
    // pass-through add x4
    v = vid(v, 1, 32'h100, 1, 2, 1, 1, 4, 32'h11, 32'h22, 32'hFFFF_FFFC, 8'h5A, 1, 0);
    v = vpr(v, 0, 0, 0, 0, 0, 0); v = vnow(v, 0, 0, 0, 0);
    v = vimm(vpost(v, 1, 32'h100, 4, 1, 0, 8'h5A), 32'hFFFF_FFFC); tbl.push_back(v);
    // lw x5 while add x4 in EX
    v = vid(v, 1, 32'h104, 2, 9, 1, 0, 5, 32'h1000, 32'h77, 8, 8'h11, 1, 1);
    v = vpr(v, 0, 0, 0, 0, 0, 0); v = vnow(v, 0, 1, 32'h11, 32'h22);
    v = vpost(v, 1, 32'h104, 5, 1, 1, 8'h11); tbl.push_back(v);
    // add x6,x5,x1: load-use on rs1
    v = vid(v, 1, 32'h108, 5, 1, 1, 1, 6, 32'h5555, 32'h1111, 0, 8'h22, 1, 0);
    v = vpr(v, 4, 1, 32'h44, 0, 0, 0); v = vnow(v, 1, 1, 32'h1000, 32'h77);
    v = vimm(vpost(v, 0, 32'h104, 5, 0, 0, 0), 8); tbl.push_back(v);
    v = vpr(v, 5, 1, 32'hBAD0, 4, 1, 32'h44); v = vnow(v, 0, 0, 0, 0);
    v = vpost(v, 1, 32'h108, 6, 1, 0, 8'h22); tbl.push_back(v);
    // x5 arrives from MEM/WB
    v = vid(v, 1, 32'h10C, 6, 5, 1, 1, 8, 0, 32'hDEAD, 0, 8'h33, 1, 0);
    v = vpr(v, 5, 0, 0, 5, 1, 32'hDEAD); v = vnow(v, 0, 1, 32'hDEAD, 32'h1111);
    v = vpost(v, 1, 32'h10C, 8, 1, 0, 8'h33); tbl.push_back(v);
    v = vid(v, 1, 32'h110, 3, 3, 1, 1, 9, 32'hC, 32'hD, 32'h10, 8'h44, 1, 0);
    v = vpr(v, 6, 1, 32'h66, 5, 0, 0); v = vnow(v, 0, 1, 32'h66, 32'hDEAD);
    v = vpost(v, 1, 32'h110, 9, 1, 0, 8'h44); tbl.push_back(v);
    // forward priority on rs1=rs2=3
    v = vpr(v, 3, 1, 32'hA, 3, 1, 32'hB); v = vnow(v, 0, 1, 32'hA, 32'hA); tbl.push_back(v);
    v = vpr(v, 0, 1, 32'hA, 3, 1, 32'hB); v = vnow(v, 0, 1, 32'hB, 32'hB); tbl.push_back(v);
    v.valid = 1'b0;
    v = vpr(v, 0, 1, 32'hA, 0, 1, 32'hB); v = vnow(v, 0, 1, 32'hC, 32'hD);
    v = vpost(v, 0, 32'h110, 9, 0, 0, 8'h44); tbl.push_back(v);
    // lw x10, then flush on the dependent add
    v = vid(v, 1, 32'h200, 1, 0, 1, 0, 10, 32'h30, 0, 4, 8'h55, 1, 1);
    v = vpr(v, 0, 0, 0, 0, 0, 0); v = vnow(v, 0, 0, 0, 0);
    v = vpost(v, 1, 32'h200, 10, 1, 1, 8'h55); tbl.push_back(v);
    v = vid(v, 1, 32'h204, 10, 10, 1, 1, 11, 0, 0, 0, 8'h66, 1, 0); v.flush = 1'b1;
    v = vnow(v, 0, 1, 32'h30, 0);
    v = vimm(vpost(v, 0, 32'h200, 10, 0, 0, 0), 4); tbl.push_back(v);
    // lw x12, then hazard through rs2 only (rs1 not used)
    v = vid(v, 1, 32'h300, 9, 0, 1, 0, 12, 32'h99, 0, 1, 8'h77, 1, 1);
    v = vpr(v, 10, 1, 32'h1234, 0, 0, 0); v = vnow(v, 0, 0, 0, 0);
    v = vpost(v, 1, 32'h300, 12, 1, 1, 8'h77); tbl.push_back(v);
    v = vid(v, 1, 32'h304, 12, 12, 0, 1, 14, 3, 4, 0, 8'h12, 1, 0);
    v = vpr(v, 0, 0, 0, 0, 0, 0); v = vnow(v, 1, 1, 32'h99, 0);
    v = vpost(v, 0, 32'h300, 12, 0, 0, 0); tbl.push_back(v);
    v = vpr(v, 12, 1, 32'hAAAA, 0, 0, 0); v = vnow(v, 0, 0, 0, 0);
    v = vpost(v, 1, 32'h304, 14, 1, 0, 8'h12); tbl.push_back(v);
    // lw x0 then a reader of x0: neither stalls nor forwards
    v = vid(v, 1, 32'h400, 0, 0, 1, 0, 0, 5, 6, 0, 8'h88, 1, 1);
    v = vpr(v, 0, 0, 0, 12, 1, 32'h5678); v = vnow(v, 0, 1, 32'h5678, 32'h5678);
    v = vpost(v, 1, 32'h400, 0, 1, 1, 8'h88); tbl.push_back(v);
    v = vid(v, 1, 32'h404, 0, 0, 1, 1, 13, 0, 0, 0, 8'h99, 1, 0);
    v = vpr(v, 0, 1, 32'hFFFF, 0, 1, 32'hEEEE); v = vnow(v, 0, 1, 5, 6);
    v = vpost(v, 1, 32'h404, 13, 1, 0, 8'h99); tbl.push_back(v);
  endtask
`else
  task automatic build_table();
    vec_t v = '{default: '0};
    // add x7
    v = vid(v, 1, 32'h100, 1, 2, 1, 1, 7, 32'h11, 32'h22, 32'hFFFF_FFFC, 8'h5A, 1, 0);
    v = vpr(v, 0, 0, 0, 0, 0, 0); v = vnow(v, 0, 0, 0, 0);
    v = vimm(vpost(v, 1, 32'h100, 7, 1, 0, 8'h5A), 32'hFFFF_FFFC); tbl.push_back(v);
    // sub x8,x7,x3 stalls against EX, then against EX/MEM
    v = vid(v, 1, 32'h104, 7, 3, 1, 1, 8, 32'hBAD, 32'h33, 0, 8'h11, 1, 0);
    v = vnow(v, 1, 1, 32'h11, 32'h22);
    v = vimm(vpost(v, 0, 32'h100, 7, 0, 0, 0), 32'hFFFF_FFFC); tbl.push_back(v);
    v = vpr(v, 7, 1, 32'h77, 0, 0, 0); v = vnow(v, 1, 0, 0, 0); tbl.push_back(v);
    v.rd1 = 32'h77;
    v = vpr(v, 0, 0, 0, 7, 1, 32'h77); v = vnow(v, 0, 0, 0, 0);
    v = vpost(v, 1, 32'h104, 8, 1, 0, 8'h11); tbl.push_back(v);
    // invalid ID; producers present but nothing is forwarded
    v = vid(v, 0, 32'h108, 7, 0, 1, 0, 9, 1, 2, 0, 8'h22, 1, 1);
    v = vpr(v, 7, 1, 32'hAAAA, 3, 1, 32'hBBBB); v = vnow(v, 0, 1, 32'h77, 32'h33);
    v = vpost(v, 0, 32'h108, 9, 0, 0, 8'h22); tbl.push_back(v);
    // lw x10, then flush on the dependent add
    v = vid(v, 1, 32'h200, 1, 0, 1, 0, 10, 32'h30, 0, 4, 8'h55, 1, 1);
    v = vpr(v, 0, 0, 0, 0, 0, 0); v = vnow(v, 0, 0, 0, 0);
    v = vpost(v, 1, 32'h200, 10, 1, 1, 8'h55); tbl.push_back(v);
    v = vid(v, 1, 32'h204, 10, 10, 1, 1, 11, 0, 0, 0, 8'h66, 1, 0); v.flush = 1'b1;
    v = vnow(v, 0, 1, 32'h30, 0);
    v = vimm(vpost(v, 0, 32'h200, 10, 0, 0, 0), 4); tbl.push_back(v);
    // reader of x10 stalls on EX/MEM, not on MEM/WB
    v = vid(v, 1, 32'h300, 10, 0, 1, 0, 0, 1, 0, 1, 8'h77, 1, 0);
    v = vpr(v, 10, 1, 32'h1234, 0, 0, 0); v = vnow(v, 1, 0, 0, 0);
    v = vpost(v, 0, 32'h200, 10, 0, 0, 0); tbl.push_back(v);
    v.rd1 = 32'hDEAD;
    v = vpr(v, 0, 0, 0, 10, 1, 32'hDEAD); v = vnow(v, 0, 0, 0, 0);
    v = vpost(v, 1, 32'h300, 0, 1, 0, 8'h77); tbl.push_back(v);
    // x0 producers in EX and EX/MEM never stall
    v = vid(v, 1, 32'h304, 0, 0, 1, 1, 13, 0, 0, 0, 8'h99, 1, 0);
    v = vpr(v, 0, 1, 32'hFFFF, 0, 0, 0); v = vnow(v, 0, 1, 32'hDEAD, 0);
    v = vpost(v, 1, 32'h304, 13, 1, 0, 8'h99); tbl.push_back(v);
  endtask
`endif

  task automatic drive(input vec_t v);
    bus.id_valid = v.valid;   bus.id_pc = v.pc;       bus.id_rs1 = v.rs1;
    bus.id_rs2 = v.rs2;       bus.id_rd = v.rd;       bus.id_use_rs1 = v.u1;
    bus.id_use_rs2 = v.u2;    bus.id_rd1 = v.rd1;     bus.id_rd2 = v.rd2;
    bus.id_imm = v.imm;       bus.id_ctrl = v.ctrl;   bus.id_reg_write = v.rw;
    bus.id_mem_read = v.mr;   bus.ex_flush = v.flush;
    bus.exm_rd = v.exm_rd;    bus.exm_reg_write = v.exm_rw; bus.exm_result = v.exm_res;
    bus.wb_rd = v.wb_rd;      bus.wb_reg_write = v.wb_rw;   bus.wb_result = v.wb_res;
  endtask

  task automatic drive_random_id();
    bus.id_valid = 1'($urandom());    bus.id_pc = $urandom();
    bus.id_rs1 = 5'($urandom());      bus.id_rs2 = 5'($urandom());
    bus.id_rd = 5'($urandom());       bus.id_use_rs1 = 1'($urandom());
    bus.id_use_rs2 = 1'($urandom());  bus.id_rd1 = $urandom();
    bus.id_rd2 = $urandom();          bus.id_imm = $urandom();
    bus.id_ctrl = 8'($urandom());     bus.id_reg_write = 1'($urandom());
    bus.id_mem_read = 1'($urandom()); bus.ex_flush = 1'($urandom());
    bus.exm_rd = 0; bus.exm_reg_write = 0; bus.exm_result = 0;
    bus.wb_rd = 0;  bus.wb_reg_write = 0;  bus.wb_result = 0;
  endtask

  task automatic check_post(input post_t p);
    string t;
    t = $sformatf("v%0d", p.idx);
    chk({t, " ex_valid"}, 32'(bus.ex_valid), 32'(p.valid));
    chk({t, " ex_pc"}, bus.ex_pc, p.pc);
    chk({t, " ex_rd"}, 32'(bus.ex_rd), 32'(p.rd));
    chk({t, " ex_reg_write"}, 32'(bus.ex_reg_write), 32'(p.rw));
    chk({t, " ex_mem_read"}, 32'(bus.ex_mem_read), 32'(p.mr));
    chk({t, " ex_ctrl"}, 32'(bus.ex_ctrl), 32'(p.ctrl));
    if (p.chk_imm) chk({t, " ex_imm"}, bus.ex_imm, p.imm);
  endtask

  initial begin
    vec_t  v;
    post_t p;
    build_table();

    reset = 1'b1;
    drive_random_id();
    @(posedge clk); #1;
    drive_random_id();
    @(posedge clk); #1;
    chk("reset ex_valid", 32'(bus.ex_valid), 0);
    chk("reset ex_reg_write", 32'(bus.ex_reg_write), 0);
    chk("reset ex_mem_read", 32'(bus.ex_mem_read), 0);
    chk("reset ex_ctrl", 32'(bus.ex_ctrl), 0);
    chk("reset ex_pc", bus.ex_pc, 0);
    chk("reset stall_id", 32'(bus.stall_id), 0);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      drive(v);
      #3;
      chk($sformatf("v%0d stall_id", i), 32'(bus.stall_id), 32'(v.e_stall));
      if (v.chk_op) begin
        chk($sformatf("v%0d ex_op_a", i), bus.ex_op_a, v.e_op_a);
        chk($sformatf("v%0d ex_op_b", i), bus.ex_op_b, v.e_op_b);
      end
      sb.push_back('{i, v.e_valid, v.e_pc, v.e_rd, v.e_rw, v.e_mr, v.e_ctrl, v.chk_imm, v.e_imm});
      @(posedge clk); #1;
      if (sb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL scoreboard: got empty queue expected entry for v%0d", i);
      end else begin
        p = sb.pop_front();
        check_post(p);
      end
    end

    // reset wins over a live load with flush low
    v = tbl[0];
    drive(v);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("reset-over-load ex_valid", 32'(bus.ex_valid), 0);
    chk("reset-over-load ex_reg_write", 32'(bus.ex_reg_write), 0);
    chk("reset-over-load ex_ctrl", 32'(bus.ex_ctrl), 0);
    chk("reset-over-load ex_pc", bus.ex_pc, 0);
    chk("reset-over-load stall_id", 32'(bus.stall_id), 0);
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
